// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the handshake FIFO.
// Occupancy classes and the count-width function live here.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int FIFO_BITS_DEF  = 64;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with increment and synchronous clear.
// Wraps from 2**W-1 to 0 by natural overflow.
module fifo_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    logic [W-1:0] r_ptr;

    // Clear wins over increment so a flush always lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/hs_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides.
// Register-array storage; flush clears pointers and count only.
module hs_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int BITS  = FIFO_BITS_DEF,
    parameter int AFULL = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [BITS-1:0]           in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [BITS-1:0]           out_data,
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF   = CW'(AFULL);

    logic [BITS-1:0] r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_wr_ptr;
    logic [PW-1:0]   w_rd_ptr;
    logic            w_push;
    logic            w_pop;
    occ_e            w_occ;

    // Classify occupancy from the registered count.
    always_comb begin
        w_occ = OCC_PARTIAL;
        if (r_count == '0) begin
            w_occ = OCC_EMPTY;
        end else if (r_count == C_FULL) begin
            w_occ = OCC_FULL;
        end
    end

    assign in_ready  = (w_occ != OCC_FULL);
    assign out_valid = (w_occ != OCC_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_push),
        .clr   (flush),
        .ptr   (w_wr_ptr)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_pop),
        .clr   (flush),
        .ptr   (w_rd_ptr)
    );

    // Storage: cleared on reset, written on accepted push only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    // Occupancy counter; push and pop together cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign out_data    = r_mem[w_rd_ptr];
    assign count       = r_count;
    assign almost_full = (r_count >= C_AF);

endmodule

// File: tb/tb_hs_fifo.sv
// Self-checking bench for hs_fifo: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_hs_fifo;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int AFULL = DEPTH - 2;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            in_ready;
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic            out_ready;
    logic [3:0]      count;
    logic            almost_full;

    logic [BITS-1:0] q[$];
    int n_cmp;
    int n_bad;

    hs_fifo #(.DEPTH(DEPTH), .BITS(BITS), .AFULL(AFULL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model outputs derived from the queue contents.
    task automatic compare();
        int sz;
        sz = q.size();
        chk("count", 64'(count), 64'(sz));
        chk("out_valid", 64'(out_valid), 64'(sz != 0));
        chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
        chk("almost_full", 64'(almost_full), 64'(sz >= AFULL));
        if (sz != 0) chk("out_data", out_data, q[0]);
    endtask

    // Advance one clock: update model at the edge, check at negedge.
    task automatic tick();
        bit psh;
        bit pp;
        @(posedge clk);
        psh = in_valid && (q.size() != DEPTH);
        pp  = out_ready && (q.size() != 0);
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (psh) q.push_back(in_data);
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_afull", 64'(almost_full), 64'd0);
        rst_n = 1'b1;

        // Three pushes then drain in order.
        in_valid = 1'b1; in_data = 64'h11;
        tick();
        chk("s1_count1", 64'(count), 64'd1);
        chk("s1_first", out_data, 64'h11);
        in_data = 64'h22; tick();
        in_data = 64'h33; tick();
        chk("s1_peak", 64'(count), 64'd3);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("s1_pop0", out_data, 64'h11);
        tick();
        chk("s1_pop1", out_data, 64'h22);
        tick();
        chk("s1_pop2", out_data, 64'h33);
        tick();
        chk("s1_empty", 64'(count), 64'd0);

        // Fill to full, watching almost_full.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 64'(i);
            tick();
            chk("s2_afull", 64'(almost_full), 64'(i + 1 >= 6));
        end
        chk("s2_full_cnt", 64'(count), 64'd8);
        chk("s2_full_rdy", 64'(in_ready), 64'd0);
        in_data = 64'h99;
        tick();
        chk("s2_ninth_cnt", 64'(count), 64'd8);
        chk("s2_ninth_head", out_data, 64'd0);

        // Full with push+pop: only the pop happens.
        in_data = 64'h100; out_ready = 1'b1;
        tick();
        chk("s3_pop_only", 64'(count), 64'd7);
        chk("s3_head", out_data, 64'd1);
        out_ready = 1'b0;
        tick();
        chk("s3_push_next", 64'(count), 64'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (DEPTH) tick();
        chk("s3_drained", 64'(count), 64'd0);

        // Continuous stream, pointers wrap twice.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 64'(200 + i);
            tick();
            chk("s4_count", 64'(count), 64'd1);
            chk("s4_data", out_data, 64'(200 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("s4_end", 64'(count), 64'd0);

        // Flush with a concurrent write.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 64'(300 + i);
            tick();
        end
        flush = 1'b1; in_data = 64'h777;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("s5_cnt", 64'(count), 64'd0);
        chk("s5_valid", 64'(out_valid), 64'd0);
        tick();
        chk("s5_dropped", 64'(count), 64'd0);

        // Asynchronous reset mid-transfer.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 64'(400 + i);
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("s6_valid", 64'(out_valid), 64'd0);
        chk("s6_count", 64'(count), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("s6_mem", dut.r_mem[i], 64'd0);
        end
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 64'hAB;
        tick();
        in_data = 64'hCD;
        tick();
        chk("s6_first", out_data, 64'hAB);
        in_valid = 1'b0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0) ||
                        (c > 1500 && $urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = {$urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hs_fifo.md
HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 8: number of entries, power of two, at least 2.
REQ-002 The block SHALL expose parameter BITS, default 64: data word width.
REQ-003 The block SHALL expose parameter AFULL, default DEPTH-2: almost_full threshold, at most DEPTH.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-007 The block SHALL have port in_valid, input, 1 bit: write side offers in_data.
REQ-008 The block SHALL have port in_data, input, BITS bits: write word.
REQ-009 The block SHALL have port in_ready, output, 1 bit: FIFO accepts a word this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds the oldest word.
REQ-011 The block SHALL have port out_data, output, BITS bits: oldest stored word.
REQ-012 The block SHALL have port out_ready, input, 1 bit: read side consumes out_data.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 The block SHALL have port almost_full, output, 1 bit: high while count >= AFULL.

Function
REQ-015 push SHALL be defined as in_valid & in_ready; pop SHALL be defined as out_valid & out_ready.
REQ-016 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0); both are combinational from registered state only.
REQ-017 The FIFO SHALL operate first-word-fall-through: out_data = mem[rd_ptr] combinationally, and out_data is don't-care while out_valid is low.
REQ-018 A word pushed into an empty FIFO SHALL appear on out_data with out_valid high exactly 1 cycle later; there is no same-cycle bypass.
REQ-019 On push, mem[wr_ptr] <= in_data and wr_ptr SHALL increment; on pop, rd_ptr SHALL increment.
REQ-020 Pointers are $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 by natural overflow.
REQ-021 count SHALL update as +1 on push only, -1 on pop only, and be unchanged on push and pop together or on neither.
REQ-022 When full, in_ready is low, so in_valid with no pop SHALL leave state unchanged; a simultaneous pop SHALL NOT admit a push in the same cycle.
REQ-023 When empty, out_ready high SHALL cause no change; count SHALL never underflow or overflow.
REQ-024 Occupancy state SHALL be EMPTY (count=0), PARTIAL, or FULL (count=DEPTH), with transitions only via REQ-021 or flush.
REQ-025 flush SHALL take priority over push and pop: wr_ptr, rd_ptr and count go to 0 next cycle, mem is untouched, and in_ready is unaffected during the flush cycle.
REQ-026 in_data SHALL be sampled only on push, and out_data SHALL be stable while out_valid is high and out_ready is low.

Reset
REQ-027 On rst_n low, wr_ptr, rd_ptr and count SHALL clear to 0 asynchronously, giving out_valid=0, in_ready=1, almost_full=(AFULL==0).
REQ-028 All mem entries SHALL clear to 0 on reset.
REQ-029 Reset asserted mid-transfer SHALL discard all stored words, and the first push after rst_n rises SHALL be read first.

Structure
REQ-030 Package fifo_pkg SHALL hold the constants FIFO_DEPTH_DEF=8 and FIFO_BITS_DEF=64, plus the function for count width.
REQ-031 A sub-module fifo_ptr SHALL hold a parameterised wrapping pointer with inc and clr inputs, instantiated twice (write and read pointers).
REQ-032 Storage SHALL be a register array with no vendor RAM macros.

Verification
REQ-033 Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, with out_ready=1 from the 4th cycle -> out_data 0x11, 0x22, 0x33 in order; count peaks at 3, then returns to 0.
REQ-034 Push 8 words 0..7 with out_ready=0 -> count=8, in_ready=0, almost_full=1 from count 6; a 9th in_valid leaves the contents unchanged.
REQ-035 When full, assert in_valid and out_ready together for 1 cycle -> 1 pop, 0 push, count=7; the next cycle the push is accepted and count=8.
REQ-036 Stream 20 words continuously with in_valid=out_ready=1 -> count stays at 1 after the first cycle, the pointers wrap twice, and the output sequence equals the input.
REQ-037 With 5 words stored, assert flush together with in_valid -> next cycle count=0, out_valid=0, and the word offered during flush is dropped.
REQ-038 With 4 words stored, pulse rst_n low between clock edges -> out_valid=0 immediately and all mem entries read 0.
